serial_tx: RTL and testbench
============================

# serial_tx

Parallel-to-serial frame transmitter. It drives the single-bit serial line that the existing receive-side registers sample on `IN`. It accepts one `DATA_W`-bit word per valid/ready handshake and shifts out a framed word: start bit 0, data LSB first, stop bit 1. Each bit is held for `DIV` clocks. It sits at the top level next to the receive path, sharing its `CLK`/`RST` domain.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; legal range 1..32.
- `DIV`, 4: clocks per serial bit; legal range 1..256.

Ports:
- `CLK`, input, 1: the single clock; everything is on its rising edge.
- `RST`, input, 1: reset, synchronous and active-high.
- `IN_VALID`, input, 1: a word is offered on `IN_DATA`.
- `IN_DATA`, input, `DATA_W`: word to transmit; sampled only on acceptance.
- `IN_READY`, output, 1: the block can accept a word this cycle.
- `OUT`, output, 1: serial line, registered; idle level is 1.
- `BUSY`, output, 1: a frame is in progress (any state other than IDLE).

## Operation
- FSM states are IDLE, START, DATA, STOP. Reset state is IDLE.
- Acceptance is the cycle where `IN_VALID && IN_READY`. On acceptance, `IN_DATA` loads the shift register and the FSM moves to START.
- `IN_READY` is 1 in IDLE, and also in the last cycle of STOP (baud count = `DIV`-1). It is 0 in every other cycle and whenever `RST` = 1.
- Line level per state:
  - START drives `OUT` = 0.
  - DATA drives `OUT` = shift register bit 0; the register shifts right at the end of each bit period.
  - STOP and IDLE drive `OUT` = 1.
- Baud counter counts 0..`DIV`-1 and restarts at 0 on every state entry. The bit period ends when the count reaches `DIV`-1.
- Bit index counts 0..`DATA_W`-1 in DATA. DATA exits to STOP when the bit index is `DATA_W`-1 and the bit period ends.
- End of STOP:
  - With acceptance in that cycle, go directly to START (back-to-back, no idle gap).
  - Without acceptance, go to IDLE.
- `IN_VALID` while `IN_READY` = 0 is ignored. `IN_DATA` may change freely; the word is held internally.
- With `DIV` = 1, every bit lasts one clock and the counter is always at its terminal value.
- Reset values: `OUT` = 1, `BUSY` = 0, `IN_READY` = 0 while `RST` is high. All counters and the shift register are 0.
- `RST` asserted mid-frame: on the next edge `OUT` = 1 and the FSM returns to IDLE. The frame is truncated and dropped, with no recovery or resend.

## Timing
- Acceptance at edge N: `OUT` falls to 0 after edge N+1 and `BUSY` = 1 from the same edge.
- Data bit k is driven from edge N+1+(1+k)·`DIV` for `DIV` cycles.
- Stop bit is driven from edge N+1+(1+`DATA_W`)·`DIV`.
- Frame length is exactly (`DATA_W`+2)·`DIV` clocks.
- Throughput:
  - Back-to-back: one frame per (`DATA_W`+2)·`DIV` clocks.
  - Otherwise a frame started from IDLE follows the previous one after at least 1 idle clock.
- First `IN_READY` = 1 is in the cycle after `RST` deasserts.

## Structure
- Shared package `serial_pkg`:
  - State enum `tx_state_t` (IDLE/START/DATA/STOP).
  - Constant `LINE_IDLE` = 1'b1.
  - Constant `START_LVL` = 1'b0.
  - The receive side imports the same package.
- One sub-module, `serial_baud_cnt`:
  - Parameter: `DIV`.
  - Inputs: `CLK`, `RST`, `restart`.
  - Output: `tick` = 1 when the count equals `DIV`-1.
  - Counter width is $clog2(`DIV`), minimum 1.
- Top contains the FSM, bit index, shift register and output register.

## Test plan
- Reset, then idle 20 clocks → `OUT` = 1, `BUSY` = 0, `IN_READY` = 1 from the first cycle after `RST` falls.
- `DATA_W`=8, `DIV`=4, send 8'hA5 → line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. Total 40 clocks, then `BUSY` = 0.
- Two words 8'h00 then 8'hFF with `IN_VALID` held high → second start bit begins immediately after the first stop bit. No idle clock between frames; `IN_READY` pulses only in the last STOP cycle.
- `IN_VALID` pulsed with 8'h3C while `BUSY` and `IN_READY` = 0 → word ignored; the frame in progress is unchanged; no extra frame follows.
- `RST` asserted for 1 clock during data bit 3 of 8'h81 → `OUT` = 1 next edge, FSM in IDLE, `BUSY` = 0. A new word accepted afterwards transmits correctly.
- `DIV`=1, `DATA_W`=1, send 1'b1 → line 0,1,1 over exactly 3 clocks.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit and receive paths.
// Holds the frame FSM states, the line levels and a counter-width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_baud_cnt.sv
// Per-bit baud counter: counts 0..DIV-1 and flags the last clock of a bit period.
// A restart forces the count back to 0 on the following edge.
module serial_baud_cnt
  import serial_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit 0, DATA_W bits LSB first, stop bit 1,
// each bit held DIV clocks. Accepts a new word in the last stop cycle for gapless frames.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              OUT,
  output logic              BUSY
);

  localparam int unsigned IdxW = cnt_width(DATA_W);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              out_q, out_d;
  logic              tick;
  logic              restart;
  logic              accept;

  // Ready in IDLE and in the final STOP cycle, so back-to-back frames have no gap.
  assign IN_READY = !RST && ((state_q == IDLE) || ((state_q == STOP) && tick));
  assign accept   = IN_VALID && IN_READY;

  // Holding the counter at 0 in IDLE keeps START a full bit period long.
  assign restart = (state_d != state_q) || (state_q == IDLE);

  serial_baud_cnt #(
    .DIV (DIV)
  ) u_baud (
    .CLK     (CLK),
    .RST     (RST),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = IN_DATA;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IdxLast) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (accept) begin
            state_d = START;
            shift_d = IN_DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is registered from the next state so OUT changes with the state.
  always_comb begin
    out_d = LINE_IDLE;
    unique case (state_d)
      START:   out_d = START_LVL;
      DATA:    out_d = shift_d[0];
      default: out_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
    end
  end

  assign OUT  = out_q;
  assign BUSY = !RST && (state_q != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a bit-stream queue model checked every cycle, plus literal frame checks.
// A second instance covers the DIV=1, DATA_W=1 corner.
module tb_serial_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned DV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          ready, out, busy;
  logic          v2 = 1'b0;
  logic [0:0]    d2 = 1'b0;
  logic          ready2, out2, busy2;

  always #5 clk = ~clk;

  serial_tx #(
    .DATA_W (DW),
    .DIV    (DV)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .IN_VALID (valid),
    .IN_DATA  (data),
    .IN_READY (ready),
    .OUT      (out),
    .BUSY     (busy)
  );

  serial_tx #(
    .DATA_W (1),
    .DIV    (1)
  ) dut1 (
    .CLK      (clk),
    .RST      (rst),
    .IN_VALID (v2),
    .IN_DATA  (d2),
    .IN_READY (ready2),
    .OUT      (out2),
    .BUSY     (busy2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted word expands into its line levels, one queue entry per clock.
  logic m_q[$];
  logic m_cur = 1'b1;
  bit   m_active = 1'b0;
  bit   started = 1'b0;
  logic log_out[$];
  logic log_busy[$];

  initial begin
    bit acc;
    forever begin
      @(posedge clk);
      acc = valid && !rst && (!m_active || (m_q.size() == 0));
      if (rst) begin
        m_q.delete();
        m_active = 1'b0;
        m_cur    = 1'b1;
      end else begin
        if (acc) begin
          for (int j = 0; j < DV; j++) m_q.push_back(1'b0);
          for (int k = 0; k < DW; k++)
            for (int j = 0; j < DV; j++) m_q.push_back(data[k]);
          for (int j = 0; j < DV; j++) m_q.push_back(1'b1);
        end
        if (m_q.size() > 0) begin
          m_cur    = m_q.pop_front();
          m_active = 1'b1;
        end else begin
          m_cur    = 1'b1;
          m_active = 1'b0;
        end
      end
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("out", 32'(out), 32'(m_cur));
        check("busy", 32'(busy), 32'(!rst && m_active));
        check("ready", 32'(ready), 32'(!rst && (!m_active || (m_q.size() == 0))));
        log_out.push_back(out);
        log_busy.push_back(busy);
      end
    end
  end

  // Called just after a posedge with the DUT idle; the word is accepted on the next edge.
  task automatic send(input logic [DW-1:0] w);
    valid = 1'b1;
    data  = w;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = DW'($urandom);
    log_out.delete();
    log_busy.delete();
  endtask

  logic [9:0] exp_a5;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("idle_out", 32'(out), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single frame 8'hA5.
    send(8'hA5);
    repeat (42) @(posedge clk);
    #1;
    exp_a5 = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d_first", i), 32'(log_out[4*i]), 32'(exp_a5[i]));
      check($sformatf("a5_bit%0d_last", i), 32'(log_out[4*i+3]), 32'(exp_a5[i]));
    end
    check("a5_busy_last", 32'(log_busy[39]), 32'd1);
    check("a5_busy_after", 32'(log_busy[40]), 32'd0);

    // Back-to-back 8'h00 then 8'hFF with valid held high.
    valid = 1'b1;
    data  = 8'h00;
    @(posedge clk);
    #1;
    data = 8'hFF;
    log_out.delete();
    log_busy.delete();
    repeat (40) @(posedge clk);
    #1 valid = 1'b0;
    repeat (42) @(posedge clk);
    #1;
    check("b2b_first_bit0", 32'(log_out[4]), 32'd0);
    check("b2b_first_stop", 32'(log_out[39]), 32'd1);
    check("b2b_second_start", 32'(log_out[40]), 32'd0);
    check("b2b_second_bit0", 32'(log_out[44]), 32'd1);
    check("b2b_busy_gap", 32'(log_busy[40]), 32'd1);
    check("b2b_busy_end", 32'(log_busy[80]), 32'd0);

    // Offer 8'h3C mid-frame: must be ignored.
    send(8'h96);
    repeat (10) @(posedge clk);
    #1;
    valid = 1'b1;
    data  = 8'h3C;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("ign_bit0", 32'(log_out[4]), 32'd0);
    check("ign_bit1", 32'(log_out[8]), 32'd1);
    check("ign_after_out", 32'(log_out[40]), 32'd1);
    check("ign_after_busy", 32'(log_busy[40]), 32'd0);
    check("ign_late_busy", 32'(log_busy[50]), 32'd0);

    // Reset during data bit 3 of 8'h81, then a fresh frame.
    send(8'h81);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out", 32'(out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    send(8'h5C);
    repeat (45) @(posedge clk);
    #1;
    check("post_rst_bit2", 32'(log_out[12]), 32'd1);
    check("post_rst_bit1", 32'(log_out[8]), 32'd0);

    // DIV=1, DATA_W=1 instance sends 1'b1.
    check("d1_idle_out", 32'(out2), 32'd1);
    v2 = 1'b1;
    d2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    @(negedge clk);
    check("d1_c0_out", 32'(out2), 32'd0);
    check("d1_c0_busy", 32'(busy2), 32'd1);
    check("d1_c0_ready", 32'(ready2), 32'd0);
    @(negedge clk);
    check("d1_c1_out", 32'(out2), 32'd1);
    check("d1_c1_busy", 32'(busy2), 32'd1);
    check("d1_c1_ready", 32'(ready2), 32'd0);
    @(negedge clk);
    check("d1_c2_out", 32'(out2), 32'd1);
    check("d1_c2_busy", 32'(busy2), 32'd1);
    check("d1_c2_ready", 32'(ready2), 32'd1);
    @(negedge clk);
    check("d1_c3_out", 32'(out2), 32'd1);
    check("d1_c3_busy", 32'(busy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
